// File: rtl/sd_pkg.sv
// SD CMD-line responder shared types and constants.
// R2 (136-bit) response support is enabled by SD_RESP_R2_EN.
package sd_pkg;

  localparam int CMD_LEN = 48;
  localparam int R2_LEN  = 136;
  localparam logic [6:0] CRC7_POLY = 7'h09;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX,
    S_CHECK,
    S_WAIT_RSP,
    S_NCR_GAP,
    S_TX
  } state_t;

  function automatic logic [6:0] crc7_step(
    input logic [6:0] c,
    input logic       d
  );
    logic fb;
    fb = c[6] ^ d;
    return {c[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7+x^3+1); clear with en restarts from zero on din.
// Shared by command check and response generation.
module sd_crc7
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= '0;
    end else if (en) begin
      crc <= crc7_step(clear ? 7'h00 : crc, din);
    end else if (clear) begin
      crc <= '0;
    end
  end

endmodule

// File: rtl/sd_card_cmd_responder.sv
// SD card CMD-line command receiver and response transmitter.
// Define SD_RESP_R2_EN to support 136-bit R2 responses.
module sd_card_cmd_responder
  import sd_pkg::*;
#(
  parameter int NCR         = 2,
  parameter int RSP_TIMEOUT = 64
) (
  input  logic         ex_clk,
  input  logic         ex_resetn,
  input  logic         bit_tick,
  input  logic         cmd_in,
  output logic         cmd_out,
  output logic         cmd_oe,
  output logic         cmd_valid,
  output logic [5:0]   cmd_index,
  output logic [31:0]  cmd_arg,
  output logic         cmd_crc_err,
  input  logic         rsp_valid,
  output logic         rsp_ready,
  input  logic         rsp_long,
  input  logic [127:0] rsp_data,
  output logic         busy
);

  localparam logic [15:0] NCR_LAST = 16'(NCR - 1);
  localparam logic [15:0] TO_LAST  = 16'(RSP_TIMEOUT - 1);
  localparam logic [15:0] RX_LAST  = 16'(CMD_LEN - 1);
  localparam logic [15:0] CRC_POS  = 16'(CMD_LEN - 8);

  state_t        state;
  logic [15:0]   cnt;
  logic [47:0]   rx_sr;
  logic [135:0]  tx_sr;
  logic [135:0]  tx_load;
  logic [15:0]   tx_len;
  logic          tx_long;
  logic [6:0]    crc;
  logic          crc_clear;
  logic          crc_en;
  logic          crc_din;
  logic          frame_ok;

`ifdef SD_RESP_R2_EN
  logic unused_rsp;
  assign unused_rsp = rsp_data[0];
  assign tx_load = rsp_long
    ? {2'b00, 6'h3f, rsp_data[127:1], 1'b1}
    : {2'b00, rsp_data[37:0], 96'b0};

  always_ff @(posedge ex_clk or negedge ex_resetn) begin
    if (!ex_resetn) begin
      tx_long <= 1'b0;
    end else if (state == S_WAIT_RSP && rsp_valid) begin
      tx_long <= rsp_long;
    end
  end
`else
  logic unused_rsp;
  assign unused_rsp = ^{rsp_long, rsp_data[127:38]};
  assign tx_load = {2'b00, rsp_data[37:0], 96'b0};
  assign tx_long = 1'b0;
`endif

  assign tx_len    = tx_long ? 16'(R2_LEN) : 16'(CMD_LEN);
  assign busy      = (state != S_IDLE);
  assign rsp_ready = (state == S_WAIT_RSP);
  assign frame_ok  = ~rx_sr[47] & rx_sr[46] & rx_sr[0]
                   & (crc == rx_sr[7:1]);

  // The start bit is folded in from IDLE so RX only feeds bits 46:8.
  assign crc_clear = state inside {S_IDLE, S_WAIT_RSP, S_NCR_GAP};
  assign crc_din   = (state == S_TX) ? tx_sr[135] : cmd_in;
  assign crc_en    = bit_tick &
    (((state == S_IDLE) & ~cmd_in & ~cmd_oe) |
     (((state == S_RX) | (state == S_TX)) & (cnt < CRC_POS)));

  sd_crc7 u_crc7 (
    .clk   (ex_clk),
    .rst_n (ex_resetn),
    .clear (crc_clear),
    .en    (crc_en),
    .din   (crc_din),
    .crc   (crc)
  );

  always_ff @(posedge ex_clk or negedge ex_resetn) begin
    if (!ex_resetn) begin
      state       <= S_IDLE;
      cnt         <= '0;
      rx_sr       <= '0;
      tx_sr       <= '0;
      cmd_out     <= 1'b1;
      cmd_oe      <= 1'b0;
      cmd_valid   <= 1'b0;
      cmd_crc_err <= 1'b0;
      cmd_index   <= '0;
      cmd_arg     <= '0;
    end else begin
      cmd_valid   <= 1'b0;
      cmd_crc_err <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bit_tick && !cmd_in && !cmd_oe) begin
            state <= S_RX;
            cnt   <= 16'd1;
            rx_sr <= '0;
          end
        end
        S_RX: begin
          if (bit_tick) begin
            rx_sr <= {rx_sr[46:0], cmd_in};
            cnt   <= cnt + 16'd1;
            if (cnt == RX_LAST) state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (frame_ok) begin
            cmd_index <= rx_sr[45:40];
            cmd_arg   <= rx_sr[39:8];
            cmd_valid <= 1'b1;
            cnt       <= '0;
            state     <= S_WAIT_RSP;
          end else begin
            cmd_crc_err <= 1'b1;
            state       <= S_IDLE;
          end
        end
        S_WAIT_RSP: begin
          if (rsp_valid) begin
            tx_sr   <= tx_load;
            cnt     <= '0;
            cmd_oe  <= 1'b1;
            cmd_out <= 1'b1;
            state   <= S_NCR_GAP;
          end else if (bit_tick) begin
            cnt <= cnt + 16'd1;
            if (cnt == TO_LAST) state <= S_IDLE;
          end
        end
        S_NCR_GAP: begin
          if (bit_tick) begin
            if (cnt == NCR_LAST) begin
              cnt   <= '0;
              state <= S_TX;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
        end
        S_TX: begin
          if (bit_tick) begin
            cnt <= cnt + 16'd1;
            if (cnt == tx_len) begin
              cmd_oe  <= 1'b0;
              cmd_out <= 1'b1;
              state   <= S_IDLE;
            end else if (!tx_long && cnt == CRC_POS) begin
              // Splice the finished CRC and end bit into the shifter.
              cmd_out <= crc[6];
              tx_sr   <= {crc[5:0], 1'b1, 129'b0};
            end else begin
              cmd_out <= tx_sr[135];
              tx_sr   <= {tx_sr[134:0], 1'b0};
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/sd_card_cmd_responder.md
SD_CARD_CMD_RESPONDER -- requirements
Module: sd_card_cmd_responder

Interface
REQ-001 SHALL have parameter NCR, default 2: idle bit-times between the command end bit and the response start bit (minimum 2).
REQ-002 SHALL have parameter RSP_TIMEOUT, default 64: bit-times to wait for rsp_valid before abandoning the response.
REQ-003 ex_clk  input  1  single system clock; all logic on its rising edge.
REQ-004 ex_resetn  input  1  reset, asynchronous and active-low.
REQ-005 bit_tick  input  1  one-ex_clk strobe marking one SD bit-time; CMD is sampled or driven only on ticks.
REQ-006 cmd_in  input  1  sampled CMD line.
REQ-007 cmd_out  output  1  value driven onto CMD.
REQ-008 cmd_oe  output  1  CMD drive enable (1 = card drives).
REQ-009 cmd_valid  output  1  one-cycle pulse: good command captured.
REQ-010 cmd_index  output  6  captured command index.
REQ-011 cmd_arg  output  32  captured argument.
REQ-012 cmd_crc_err  output  1  one-cycle pulse: framing or CRC7 failure.
REQ-013 rsp_valid  input  1  user offers a response.
REQ-014 rsp_ready  output  1  responder accepts the response.
REQ-015 rsp_long  input  1  1 = 136-bit R2, 0 = 48-bit.
REQ-016 rsp_data  input  128  48-bit: [37:32] index, [31:0] argument; R2: [127:1] CID/CSD including its CRC7.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 States SHALL be IDLE, RX, CHECK, WAIT_RSP, NCR_GAP, TX.
REQ-019 IDLE->RX on a tick with cmd_in=0 (start bit); RX SHALL shift 47 further bits MSB-first, one per tick.
REQ-020 CHECK SHALL verify transmission bit=1, end bit=1 and CRC7 (x^7+x^3+1) over bits 47:8.
- Pass: load cmd_index and cmd_arg, pulse cmd_valid, go to WAIT_RSP.
- Fail: pulse cmd_crc_err, return to IDLE.
REQ-021 rsp_ready SHALL be high only in WAIT_RSP; the handshake completes on the ex_clk edge with rsp_valid&&rsp_ready, latching rsp_data and rsp_long.
REQ-022 rsp_valid outside WAIT_RSP SHALL be ignored.
REQ-023 After RSP_TIMEOUT ticks in WAIT_RSP without a handshake, the block SHALL return to IDLE silently (no-response commands).
REQ-024 NCR_GAP SHALL hold cmd_oe=1, cmd_out=1 for NCR ticks, then enter TX.
REQ-025 48-bit TX frame: 0, 0, index[5:0], arg[31:0], generated CRC7, 1.
REQ-026 R2 TX frame: 0, 0, 111111, rsp_data[127:1], 1; no CRC is generated for R2.
REQ-027 After the end bit, cmd_oe SHALL fall on the next tick and the state SHALL return to IDLE.
REQ-028 cmd_in SHALL be ignored while cmd_oe=1.
REQ-029 cmd_valid and cmd_crc_err SHALL never assert in the same cycle.
REQ-030 Bit and timeout counters SHALL advance only on bit_tick.

Reset
REQ-031 Asserting ex_resetn low SHALL immediately force IDLE and cmd_oe=0, even mid-TX.
REQ-032 Reset values SHALL be cmd_out=1, rsp_ready=0, busy=0, all pulse outputs 0, cmd_index=0, cmd_arg=0.

Configuration
REQ-033 Macro SD_RESP_R2_EN SHALL control R2 support.
- Defined: rsp_long selects 136-bit R2.
- Undefined: rsp_long is ignored, every response is 48-bit, and R2 logic is removed.

Structure
REQ-034 Package sd_pkg SHALL hold the state enum, CMD_LEN=48, R2_LEN=136 and CRC7_POLY=7'h09.
REQ-035 Sub-module sd_crc7 (serial CRC7: clear, enable, data bit, 7-bit result) SHALL be instantiated once and shared by RX check and TX generation.

Verification
REQ-036 CMD0 frame 0x400000000095 -> cmd_valid pulse, index 0, arg 0; no rsp_valid -> IDLE after 64 ticks, cmd_oe never asserted.
REQ-037 CMD8 frame 0x48000001AA87, then 48-bit response index 8, arg 0x000001AA -> after 2 idle bit-times, cmd_out serializes 0x08000001AA13.
REQ-038 CMD8 frame with CRC byte 0x85 -> cmd_crc_err pulse, no cmd_valid, state IDLE.
REQ-039 With SD_RESP_R2_EN defined, an R2 response with rsp_data[127:1] = all ones -> 136 bits serialized, the first eight reading 0x3F, last bit 1; with the macro undefined, the same stimulus -> 48-bit frame.
REQ-040 ex_resetn pulsed low at bit 20 of TX -> cmd_oe=0 within the same cycle; a following CMD0 frame is captured correctly.
REQ-041 rsp_valid held high during RX -> no handshake until WAIT_RSP, where it completes in the first cycle.
